// File: rtl/dsp_ctrl_pkg.sv
// Shared types and constants for the DSP-slice MAC sequencer.
// Holds the FSM encoding, the slice OPMODE words and the default latencies.
package dsp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [17:0] opnd_t;
  typedef logic [47:0] acc_t;

  // OPMODE words: bit0 selects X = M, bit3 selects Z = P, bit7 subtracts.
  localparam logic [7:0] OPM_FIRST     = 8'h01;
  localparam logic [7:0] OPM_ACC       = 8'h09;
  localparam logic [7:0] OPM_HOLD      = 8'h08;
  localparam logic [7:0] OPM_FIRST_SUB = 8'h81;
  localparam logic [7:0] OPM_SUB_BIT   = 8'h80;

  localparam int LEN_W_DEF   = 10;
  localparam int OPM_DLY_DEF = 2;
  localparam int RES_LAT_DEF = 3;

  function automatic logic [7:0] beat_opmode(input logic first, input logic sub);
    if (first) return sub ? OPM_FIRST_SUB : OPM_FIRST;
    return sub ? (OPM_ACC | OPM_SUB_BIT) : OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp_opm_delay.sv
// Fixed-depth delay line that lines the OPMODE word up with the slice's M stage.
// DEPTH = 0 degenerates to a wire.
module dsp_opm_delay #(
  parameter int         DEPTH   = 2,
  parameter int         W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = d;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= {DEPTH{RST_VAL}};
        else     pipe_q <= pipe_d;
      end

      assign q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a vector multiply-accumulate job through an external DSP slice:
// feeds operands, schedules OPMODE/CE/RST and captures the final P into a result handshake.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int OPM_DLY = OPM_DLY_DEF,
  parameter int RES_LAT = RES_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_sub,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_result,
  output logic             busy
);

  localparam int DRN_W = (RES_LAT < 1) ? 1 : $clog2(RES_LAT + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
  logic             cfg_sub_q, cfg_sub_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DRN_W-1:0] drn_cnt_q, drn_cnt_d;
  opnd_t            dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
  logic [7:0]       opm_q, opm_d;
  logic             dsp_cep_q, dsp_cep_d;
  logic             dsp_rstp_q, dsp_rstp_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  acc_t             out_result_q, out_result_d;
  logic             accept, last_beat;

  assign accept    = in_valid && in_ready_q;
  assign last_beat = (beat_cnt_q == cfg_len_q - LEN_W'(1));

  always_comb begin
    state_d      = state_q;
    cfg_len_d    = cfg_len_q;
    cfg_sub_d    = cfg_sub_q;
    beat_cnt_d   = beat_cnt_q;
    drn_cnt_d    = drn_cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    dsp_rstp_d   = 1'b0;
    dsp_a_d      = '0;
    dsp_b_d      = '0;
    opm_d        = OPM_HOLD;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_len_d  = cfg_len;
          cfg_sub_d  = cfg_sub;
          beat_cnt_d = '0;
          if (cfg_len == '0) begin
            state_d      = ST_DONE;
            out_valid_d  = 1'b1;
            out_result_d = '0;
          end else begin
            state_d    = ST_RUN;
            dsp_rstp_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          dsp_a_d = in_a;
          dsp_b_d = in_b;
          opm_d   = beat_opmode(beat_cnt_q == '0, cfg_sub_q);
          if (last_beat) begin
            state_d   = ST_DRAIN;
            drn_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The first DRAIN cycle is the last beat on dsp_a; P settles RES_LAT cycles later.
        if (drn_cnt_q == DRN_W'(RES_LAT)) begin
          state_d      = ST_DONE;
          out_valid_d  = 1'b1;
          out_result_d = dsp_p;
        end else begin
          drn_cnt_d = drn_cnt_q + DRN_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_RUN);
    dsp_cep_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_len_q    <= '0;
      cfg_sub_q    <= 1'b0;
      beat_cnt_q   <= '0;
      drn_cnt_q    <= '0;
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      opm_q        <= OPM_HOLD;
      dsp_cep_q    <= 1'b0;
      dsp_rstp_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cfg_len_q    <= cfg_len_d;
      cfg_sub_q    <= cfg_sub_d;
      beat_cnt_q   <= beat_cnt_d;
      drn_cnt_q    <= drn_cnt_d;
      dsp_a_q      <= dsp_a_d;
      dsp_b_q      <= dsp_b_d;
      opm_q        <= opm_d;
      dsp_cep_q    <= dsp_cep_d;
      dsp_rstp_q   <= dsp_rstp_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  // opm_q is aligned with dsp_a; the delay line moves it to the slice's M stage.
  dsp_opm_delay #(
    .DEPTH   (OPM_DLY),
    .W       (8),
    .RST_VAL (OPM_HOLD)
  ) u_opm_delay (
    .clk (clk),
    .rst (rst),
    .d   (opm_q),
    .q   (dsp_opmode)
  );

  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_cep    = dsp_cep_q;
  assign dsp_rstp   = dsp_rstp_q;
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 10: width of the vector-length field.
REQ-002 SHALL have parameter OPM_DLY, default 2: cycles from an operand beat on dsp_a/dsp_b to its matching dsp_opmode.
REQ-003 SHALL have parameter RES_LAT, default 3: cycles from the last operand beat until dsp_p holds the final sum.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a MAC job; sampled only in IDLE.
REQ-007 cfg_len  in  LEN_W  number of operand pairs; sampled with start.
REQ-008 cfg_sub  in  1  1 = subtract-accumulate (P - A*B), 0 = add; sampled with start.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand handshake.
REQ-010 in_a, in_b  in  18 each  signed operand pair.
REQ-011 dsp_a, dsp_b  out  18 each  operands to the slice.
REQ-012 dsp_opmode  out  8  slice OPMODE.
REQ-013 dsp_cep, dsp_rstp  out  1 each  slice P clock-enable and P reset.
REQ-014 dsp_p  in  48  slice P output.
REQ-015 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-016 out_result  out  48  accumulated sum.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have these states and transitions: IDLE -> (start) RUN -> (last beat accepted) DRAIN -> (RES_LAT cycles elapsed) DONE -> (out_valid and out_ready) IDLE.
REQ-019 If start arrives with cfg_len = 0, the FSM SHALL go IDLE -> DONE directly, out_result SHALL be 0, and no operands SHALL be issued.
REQ-020 in_ready SHALL be high only in RUN; a beat is accepted when in_valid and in_ready are both high.
REQ-021 On an accepted beat, dsp_a/dsp_b SHALL be registered from in_a/in_b; otherwise they SHALL be 0.
REQ-022 Opmode selection per cycle:
  - accepted beat k = 0: 8'h01 (X = M, Z = 0);
  - beat k > 0: 8'h09 (X = M, Z = P), with bit 7 set when cfg_sub = 1;
  - bubble (no accepted beat, or IDLE/DRAIN/DONE): 8'h08 (X = 0, Z = P), so P holds.
REQ-023 The opmode for each beat SHALL be delayed by exactly OPM_DLY cycles through a shift register; bubbles SHALL enter that shift register as 8'h08.
REQ-024 The first beat with cfg_sub = 1 SHALL use 8'h81 (0 - M).
REQ-025 dsp_cep SHALL be high in RUN and DRAIN and low otherwise.
REQ-026 dsp_rstp SHALL pulse high for one cycle on the IDLE -> RUN transition.
REQ-027 The beat counter SHALL count accepted beats; the last beat is the one where count = cfg_len - 1; the counter SHALL not wrap.
REQ-028 The drain counter SHALL count RES_LAT cycles starting the cycle after the last beat; on expiry dsp_p SHALL be captured into out_result.
REQ-029 out_result and out_valid SHALL hold until out_ready is high.
REQ-030 If out_ready is high in the cycle out_valid rises, the FSM SHALL return to IDLE on the next edge.
REQ-031 start SHALL be ignored outside IDLE.
REQ-032 A start seen in the same cycle as the DONE -> IDLE transition SHALL be ignored.
REQ-033 Stalls (in_valid low) SHALL be allowed for any length and SHALL not affect the sum.

Reset
REQ-034 On rst the FSM SHALL go to IDLE, counters and the opmode shift register SHALL be cleared to 8'h08, and outputs SHALL be:
  - in_ready = 0, out_valid = 0, out_result = 0, busy = 0;
  - dsp_a = 0, dsp_b = 0, dsp_opmode = 8'h08, dsp_cep = 0, dsp_rstp = 0.
REQ-035 rst asserted mid-job SHALL abandon the job with no result; the next job's dsp_rstp pulse SHALL clear the slice.

Structure
REQ-036 State encoding, the opmode constants (8'h01, 8'h09, 8'h08, 8'h81) and the default latencies SHALL live in the shared package dsp_ctrl_pkg.
REQ-037 The opmode delay line SHALL be one sub-module, dsp_opm_delay, parameterised by depth and width.

Verification
REQ-038 cfg_len = 4, pairs (1,2), (3,4), (5,6), (7,8), no stalls -> out_result = 100, out_valid exactly RES_LAT + 1 cycles after the last beat.
REQ-039 Same vector with in_valid low for 3 cycles between beats 2 and 3 -> out_result = 100.
REQ-040 cfg_sub = 1, cfg_len = 2, pairs (2,3), (4,5) -> out_result = -26, sign-extended to 48 bits.
REQ-041 cfg_len = 0 -> out_valid within 2 cycles, out_result = 0, in_ready never high.
REQ-042 out_ready held low for 10 cycles -> result stable and no new start accepted; out_ready = 1 -> IDLE on the next edge.
REQ-043 rst asserted after beat 2 of 4, then a new job of pairs (1,1) x 3 -> out_result = 3.
